// File: rtl/mux_8to1.sv
// Registered 8-to-1 lane selector: one of eight WIDTH-bit lanes is picked by
// sel and presented on out one clock after a capture, with out_valid flagging it.
module mux_8to1 #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*WIDTH-1:0]   in,
    input  logic [2:0]           sel,
    input  logic                 en,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid
);

    logic [WIDTH-1:0] lane_s;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             valid_d;
    logic             valid_q;

    // Combinational lane pick; every sel code maps to a real lane.
    always_comb begin
        lane_s = '0;
        case (sel)
            3'd0:    lane_s = in[0*WIDTH +: WIDTH];
            3'd1:    lane_s = in[1*WIDTH +: WIDTH];
            3'd2:    lane_s = in[2*WIDTH +: WIDTH];
            3'd3:    lane_s = in[3*WIDTH +: WIDTH];
            3'd4:    lane_s = in[4*WIDTH +: WIDTH];
            3'd5:    lane_s = in[5*WIDTH +: WIDTH];
            3'd6:    lane_s = in[6*WIDTH +: WIDTH];
            3'd7:    lane_s = in[7*WIDTH +: WIDTH];
            default: lane_s = '0;
        endcase
    end

    // Next-state: load on enable, otherwise hold data and drop valid.
    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        if (en) begin
            out_d   = lane_s;
            valid_d = 1'b1;
        end else begin
            out_d   = out_q;
            valid_d = 1'b0;
        end
    end

    // Output registers; async reset clears any pending or stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_8to1.sv
// Self-checking bench for mux_8to1: directed vector table, wide-lane sweep,
// async reset corner cases and randomized traffic against a shift-based model.
module tb_mux_8to1;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in1;
    logic [31:0] in4;
    logic [2:0]  sel;
    logic        en;
    logic        out1;
    logic        v1;
    logic [3:0]  out4;
    logic        v4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] din;
        logic [2:0] sel;
        logic       en;
        logic       exp_out;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[14];

    mux_8to1 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel), .en(en),
        .out(out1), .out_valid(v1)
    );

    mux_8to1 #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in(in4), .sel(sel), .en(en),
        .out(out4), .out_valid(v4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic       m_out1;
    logic [3:0] m_out4;
    logic       m_v;

    initial begin
        // Directed table: sweep, hold, input change under fixed sel
        for (int k = 0; k < 8; k++)
            vecs[k] = '{8'hAA, 3'(k), 1'b1, 1'(k % 2), 1'b1};
        vecs[8]  = '{8'hAA, 3'd3, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{8'hAA, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{8'hAA, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{8'hAA, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{8'h20, 3'd5, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{8'h00, 3'd5, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        in1   = 8'hFF;
        in4   = 32'h76543210;
        sel   = 3'd0;
        en    = 1'b1;

        // Reset held with capture requested: outputs stay zero
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rst_out", {31'd0, out1}, 32'd0);
            chk("rst_valid", {31'd0, v1}, 32'd0);
            chk("rst_out4", {28'd0, out4}, 32'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("rel_out", {31'd0, out1}, 32'd1);
        chk("rel_valid", {31'd0, v1}, 32'd1);

        for (int i = 0; i < 14; i++) begin
            in1 = vecs[i].din;
            sel = vecs[i].sel;
            en  = vecs[i].en;
            tick();
            chk($sformatf("vec%0d_out", i), {31'd0, out1}, {31'd0, vecs[i].exp_out});
            chk($sformatf("vec%0d_valid", i), {31'd0, v1}, {31'd0, vecs[i].exp_valid});
        end

        // Wide lanes: nibble k of 0x76543210 equals k
        in4 = 32'h76543210;
        en  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k);
            tick();
            chk($sformatf("wide_sel%0d", k), {28'd0, out4}, 32'(k));
            chk("wide_valid", {31'd0, v4}, 32'd1);
        end

        // Inputs wiggling between edges must not affect the captured value
        in1 = 8'h01; sel = 3'd0; en = 1'b1;
        #3 in1 = 8'h00;
        #2 in1 = 8'h01;
        tick();
        chk("glitch_out", {31'd0, out1}, 32'd1);

        // Async reset between edges while out=1
        in1 = 8'hFF; sel = 3'd0; en = 1'b1;
        tick();
        chk("pre_arst_out", {31'd0, out1}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out", {31'd0, out1}, 32'd0);
        chk("arst_valid", {31'd0, v1}, 32'd0);
        chk("arst_out4", {28'd0, out4}, 32'd0);
        tick();
        chk("arst_hold_out", {31'd0, out1}, 32'd0);
        chk("arst_hold_valid", {31'd0, v1}, 32'd0);
        rst_n = 1'b1;
        en = 1'b0;
        tick();
        chk("post_arst_noen", {31'd0, out1}, 32'd0);
        chk("post_arst_noen_v", {31'd0, v1}, 32'd0);

        // Randomized traffic against a shift/mask reference model
        m_out1 = 1'b0;
        m_out4 = 4'd0;
        m_v    = 1'b0;
        for (int n = 0; n < 400; n++) begin
            in1 = 8'($urandom);
            in4 = $urandom;
            sel = 3'($urandom_range(0, 7));
            en  = ($urandom_range(0, 3) != 0);
            if (en) begin
                m_out1 = 1'((in1 >> sel) & 8'd1);
                m_out4 = 4'((in4 >> (sel * 4)) & 32'hF);
                m_v    = 1'b1;
            end else begin
                m_v    = 1'b0;
            end
            tick();
            chk("rnd_out1", {31'd0, out1}, {31'd0, m_out1});
            chk("rnd_out4", {28'd0, out4}, {28'd0, m_out4});
            chk("rnd_v1", {31'd0, v1}, {31'd0, m_v});
            chk("rnd_v4", {31'd0, v4}, {31'd0, m_v});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
